// File: rtl/uint_dbl_pkg.sv
// Shared constants and the binary64 field layout for the unsigned-int to double converter.
package uint_dbl_pkg;

    localparam int DBL_BIAS   = 1023;
    localparam int DBL_EXP_W  = 11;
    localparam int DBL_FRAC_W = 52;
    localparam int INT_W      = 64;

    // Biased exponent of a value whose leading one sits at bit INT_W-1.
    localparam logic [DBL_EXP_W-1:0] EXP_TOP = DBL_EXP_W'(DBL_BIAS + INT_W - 1);

    typedef struct packed {
        logic                  sign;
        logic [DBL_EXP_W-1:0]  exp;
        logic [DBL_FRAC_W-1:0] frac;
    } dbl_t;

endpackage

// File: rtl/clz64.sv
// Combinational 64-bit leading-zero counter; an all-zero input reports 0 and is
// handled by the caller's separate zero flag.
module clz64 (
    input  logic [63:0] value,
    output logic [5:0]  lz
);

    // Ascending scan so the highest set bit is the last (winning) assignment.
    always_comb begin
        lz = 6'd0;
        for (int i = 0; i < 64; i++) begin
            if (value[i]) begin
                lz = 6'(63 - i);
            end
        end
    end

endmodule

// File: rtl/unsigned_int_to_double.sv
// Three-stage pipelined uint64 -> binary64 converter (round to nearest, ties to even).
// Optional valid sideband: define UNSIGNED_INT_TO_DOUBLE_VALID_EN to add a_valid/z_valid.
module unsigned_int_to_double
    import uint_dbl_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic [INT_W-1:0] a,
`ifdef UNSIGNED_INT_TO_DOUBLE_VALID_EN
    input  logic             a_valid,
    output logic             z_valid,
`endif
    output logic [63:0]      z
);

    logic             in_valid;
    logic             v1;
    logic             v2;
    logic [INT_W-1:0] a_q;
    logic [INT_W-1:0] norm_q;
    logic [5:0]       lz_q;
    logic             zero_q;
    logic [5:0]       lz_c;

`ifdef UNSIGNED_INT_TO_DOUBLE_VALID_EN
    assign in_valid = a_valid;
`else
    assign in_valid = 1'b1;
`endif

    clz64 u_clz (
        .value (a_q),
        .lz    (lz_c)
    );

    logic [DBL_FRAC_W-1:0] frac_c;
    logic                  guard_c;
    logic                  sticky_c;
    logic                  round_up_c;
    logic [DBL_FRAC_W:0]   frac_rnd_c;
    dbl_t                  res_c;

    // A carry out of the rounded fraction leaves its low bits all zero, so only the
    // exponent needs bumping.
    always_comb begin
        frac_c     = norm_q[62:11];
        guard_c    = norm_q[10];
        sticky_c   = |norm_q[9:0];
        round_up_c = guard_c && (sticky_c || frac_c[0]);
        frac_rnd_c = {1'b0, frac_c} + (DBL_FRAC_W+1)'(round_up_c);
        res_c.sign = 1'b0;
        res_c.exp  = EXP_TOP - {5'b0, lz_q} + {10'b0, frac_rnd_c[DBL_FRAC_W]};
        res_c.frac = frac_rnd_c[DBL_FRAC_W-1:0];
    end

    // Stages load only behind a valid slot so idle cycles leave the datapath quiet.
    always_ff @(posedge clk) begin
        if (rst) begin
            v1     <= 1'b0;
            v2     <= 1'b0;
            a_q    <= '0;
            norm_q <= '0;
            lz_q   <= '0;
            zero_q <= 1'b0;
            z      <= '0;
        end else begin
            v1 <= in_valid;
            v2 <= v1;
            if (in_valid) begin
                a_q <= a;
            end
            if (v1) begin
                lz_q   <= lz_c;
                norm_q <= a_q << lz_c;
                zero_q <= (a_q == '0);
            end
            if (v2) begin
                z <= zero_q ? 64'h0 : res_c;
            end
        end
    end

`ifdef UNSIGNED_INT_TO_DOUBLE_VALID_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            z_valid <= 1'b0;
        end else begin
            z_valid <= v2;
        end
    end
`endif

endmodule

// File: tb/tb_unsigned_int_to_double.sv
// Scoreboard bench for unsigned_int_to_double: directed vectors, a mid-stream reset
// and a random stream checked against a real-arithmetic reference conversion.
module tb_unsigned_int_to_double;

    logic        clk;
    logic        rst;
    logic [63:0] a;
    logic [63:0] z;
    logic        a_valid;
`ifdef UNSIGNED_INT_TO_DOUBLE_VALID_EN
    logic        z_valid;
`endif

    int checks   = 0;
    int failures = 0;

    logic [63:0] exp_q[$];
    logic        cur_issue;
    logic [2:0]  issue_pipe;
    logic        rst_q;

    unsigned_int_to_double dut (
        .clk     (clk),
        .rst     (rst),
        .a       (a),
`ifdef UNSIGNED_INT_TO_DOUBLE_VALID_EN
        .a_valid (a_valid),
        .z_valid (z_valid),
`endif
        .z       (z)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    // Reference conversion: both halves are exact in a double, so the single
    // rounding happens in the IEEE addition.
    function automatic logic [63:0] ref_conv(input logic [63:0] v);
        real hi;
        real lo;
        hi = real'(longint'({32'b0, v[63:32]})) * 4294967296.0;
        lo = real'(longint'({32'b0, v[31:0]}));
        return $realtobits(hi + lo);
    endfunction

    // Tracks which slots carry an operand, so the monitor knows when z is due.
    always @(posedge clk) begin
        rst_q <= rst;
        if (rst) issue_pipe <= 3'b0;
        else     issue_pipe <= {issue_pipe[1:0], cur_issue};
    end

    always @(negedge clk) begin
        if (rst_q) begin
            check_output("reset_z", z, 64'h0);
`ifdef UNSIGNED_INT_TO_DOUBLE_VALID_EN
            check_output("reset_z_valid", {63'b0, z_valid}, 64'h0);
`endif
        end else begin
`ifdef UNSIGNED_INT_TO_DOUBLE_VALID_EN
            check_output("z_valid_align", {63'b0, z_valid}, {63'b0, issue_pipe[2]});
`endif
            if (issue_pipe[2]) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("[TB] FAIL scoreboard_underflow: got output %h, expected none", z);
                end else begin
                    check_output("z_value", z, exp_q.pop_front());
                end
            end
        end
    end

    // Inputs change 2 time units after the falling edge, clear of the monitor.
    task automatic apply_stimulus(input logic [63:0] val, input logic [63:0] req, input logic vld);
        @(negedge clk);
        #2;
        rst       = 1'b0;
        a         = val;
        a_valid   = vld;
`ifdef UNSIGNED_INT_TO_DOUBLE_VALID_EN
        cur_issue = vld;
`else
        cur_issue = 1'b1;
`endif
        if (cur_issue) exp_q.push_back(req);
    endtask

    task automatic hold_reset(input int cycles, input logic [63:0] val);
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            #2;
            rst       = 1'b1;
            a         = val;
            a_valid   = 1'b1;
            cur_issue = 1'b0;
            exp_q.delete();
        end
    endtask

    logic [63:0] dir_in[10] = '{
        64'd0, 64'd1, 64'd3,
        64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
        64'h0020_0000_0000_0000, 64'h0020_0000_0000_0001,
        64'h0020_0000_0000_0002, 64'h0020_0000_0000_0003,
        64'h0040_0000_0000_0003
    };
    logic [63:0] dir_out[10] = '{
        64'h0000_0000_0000_0000, 64'h3FF0_0000_0000_0000, 64'h4008_0000_0000_0000,
        64'h43E0_0000_0000_0000, 64'h43F0_0000_0000_0000,
        64'h4340_0000_0000_0000, 64'h4340_0000_0000_0000,
        64'h4340_0000_0000_0001, 64'h4340_0000_0000_0002,
        64'h4350_0000_0000_0001
    };

    initial begin
        logic [63:0] v;
        logic        vld;
        rst       = 1'b1;
        a         = 64'd5;
        a_valid   = 1'b1;
        cur_issue = 1'b0;

        hold_reset(2, 64'd5);
        apply_stimulus(64'd5, 64'h4014_0000_0000_0000, 1'b1);

        for (int i = 0; i < 10; i++) begin
            apply_stimulus(dir_in[i], dir_out[i], 1'b1);
        end

        apply_stimulus(64'd7, 64'h401C_0000_0000_0000, 1'b1);
        apply_stimulus(64'd9, 64'h4022_0000_0000_0000, 1'b1);
        hold_reset(1, 64'd11);
        apply_stimulus(64'd10, 64'h4024_0000_0000_0000, 1'b1);

        for (int i = 0; i < 1000; i++) begin
            v = {$urandom, $urandom} >> $urandom_range(0, 63);
`ifdef UNSIGNED_INT_TO_DOUBLE_VALID_EN
            vld = ($urandom_range(0, 3) != 0);
`else
            vld = 1'b1;
`endif
            apply_stimulus(v, ref_conv(v), vld);
        end

        apply_stimulus(64'd0, 64'h0, 1'b0);
`ifndef UNSIGNED_INT_TO_DOUBLE_VALID_EN
        exp_q.pop_back();
        cur_issue = 1'b0;
`endif
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(negedge clk);
        #3;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL drain: got %0d results outstanding, expected 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
